gon_multicast_scheduler: RTL
============================

Name: gon_multicast_scheduler

Overview:
Root-side sequencer for the GON X-bus multicast tree.
- After reset it programs the per-PE tag IDs by shifting a list of IDs down the `set_id`/`id_in` scan chain.
- It then issues buffered (tag, value) packets onto the bus one at a time, holding `enable` until the addressed PE answers with `ready`.
- It sits between the PE-array top-level controller and the head of a GON X-bus row.

Parameters:
- ID_LEN, 4: width of tags and IDs.
- VALUE_LEN, 32: payload width.
- NUM_PE, 8: scan-chain length, i.e. the number of IDs shifted per configuration.
- FIFO_DEPTH, 4: packet buffer entries; power of 2, at least 2.
- TIMEOUT_CYCLES, 64: stall limit; used only with GON_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_start  in  1  single-cycle request to (re)program the ID chain.
- cfg_id_valid  in  1  configuration ID offered.
- cfg_id  in  ID_LEN  ID to shift in. Order: first ID accepted lands in the farthest PE.
- cfg_id_ready  out  1  scheduler accepts a cfg_id.
- cfg_done  out  1  level; ID chain is programmed.
- set_id  out  1  scan-chain shift strobe to every GON controller.
- id_out  out  ID_LEN  to id_in of the chain head.
- pkt_valid  in  1  packet offered.
- pkt_tag  in  ID_LEN  destination tag.
- pkt_value  in  VALUE_LEN  payload.
- pkt_ready  out  1  packet buffer has space.
- tag  out  ID_LEN  bus tag.
- enable  out  1  bus enable.
- value  out  VALUE_LEN  bus value.
- ready_in  in  1  ready returned from the bus (OR of the controllers' ready_out).
- busy  out  1  state is not IDLE, or the FIFO is non-empty.
- timeout_err  out  1  one-cycle pulse; present only with the macro.

Behaviour:

Reset (synchronous, rst high at a posedge):
- state = IDLE, counter = 0, FIFO emptied.
- set_id = 0, id_out = 0, cfg_done = 0, enable = 0, tag = 0, value = 0, timeout_err = 0.
- Combinational outputs in the first post-reset cycle: cfg_id_ready = 0, pkt_ready = 1, busy = 0.
- Reset mid-configuration or mid-transfer aborts immediately. Any partially shifted chain is not valid; cfg_done stays 0.

States: IDLE, CONFIG, RUN.

IDLE:
- cfg_start → CONFIG, counter = 0, cfg_done cleared.

CONFIG:
- cfg_id_ready = 1.
- Each cycle with cfg_id_valid & cfg_id_ready: the next cycle has set_id = 1 and id_out = cfg_id (registered, 1-cycle latency), and the counter increments. Otherwise set_id = 0 and id_out holds its value.
- When the NUM_PE-th ID is accepted, cfg_id_ready drops in the following cycle. In that same cycle the final set_id pulse occurs, state becomes RUN and cfg_done = 1.
- cfg_start during CONFIG is ignored.

RUN:
- cfg_start is honoured only when the FIFO is empty; it then goes to CONFIG, counter = 0, cfg_done = 0. With a non-empty FIFO, cfg_start is ignored.

Packet FIFO:
- Push when pkt_valid & pkt_ready, where pkt_ready = !full, in any state.
- Full: pushes blocked, with no same-cycle bypass.
- Simultaneous push and pop: occupancy unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Bus issue (combinational from the FIFO head):
- enable = (state == RUN) & !empty.
- tag and value = FIFO head when enable is 1, else 0.
- Transfer completes (pop) in a cycle with enable & ready_in.
- tag and value stay stable while enable is high and ready_in is low.
- Packets are delivered strictly in order; there is no reordering across tags.
- ready_in while enable = 0 is ignored.

Optional Feature:
Macro: GON_SCHED_TIMEOUT_EN.
- With the macro:
  - A stall counter increments each cycle with enable & !ready_in, and clears on a pop or when enable = 0.
  - On reaching TIMEOUT_CYCLES, the head packet is dropped (popped without transfer), timeout_err pulses for one cycle, and the counter clears.
- Without the macro: there is no timeout_err port and no counter. The scheduler waits indefinitely for ready_in.

Test Plan:
1. Reset, cfg_start, then IDs 7,6,5,4,3,2,1,0 offered back-to-back → set_id high for 8 consecutive cycles with id_out = 7..0 delayed by 1 cycle; cfg_done rises on the cycle of the final set_id pulse; cfg_id_ready low afterwards.
2. RUN, push (tag 3, 0xDEADBEEF) with ready_in held 1 → enable = 1, tag = 3, value = 0xDEADBEEF for exactly one cycle; FIFO empty; tag and value then read 0.
3. Push 5 packets with ready_in = 0 → pkt_ready falls after the 4th push; the 5th is held by the source. Raise ready_in → 4 pops in order; the 5th is accepted after the first pop.
4. With 2 packets buffered, pulse cfg_start → ignored, no set_id. Drain the FIFO, pulse cfg_start → CONFIG, cfg_done = 0.
5. Assert rst after 3 of 8 IDs are shifted → all outputs at reset values next cycle; a fresh cfg_start requires all 8 IDs again.
6. (GON_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES = 64) Buffer 2 packets, hold ready_in = 0 → timeout_err pulses after 64 stalled cycles; the head is dropped and the second packet is driven on the bus.

Source files
------------

// File: rtl/gon_multicast_scheduler.sv
// rtl/gon_multicast_scheduler.sv - GON X-bus root sequencer: ID scan-chain programming and in-order packet issue.
// Optional stall timeout enabled by defining GON_SCHED_TIMEOUT_EN.
module gon_multicast_scheduler #(
  parameter int ID_LEN         = 4,
  parameter int VALUE_LEN      = 32,
  parameter int NUM_PE         = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_id_valid,
  input  logic [ID_LEN-1:0]    cfg_id,
  output logic                 cfg_id_ready,
  output logic                 cfg_done,
  output logic                 set_id,
  output logic [ID_LEN-1:0]    id_out,
  input  logic                 pkt_valid,
  input  logic [ID_LEN-1:0]    pkt_tag,
  input  logic [VALUE_LEN-1:0] pkt_value,
  output logic                 pkt_ready,
  output logic [ID_LEN-1:0]    tag,
  output logic                 enable,
  output logic [VALUE_LEN-1:0] value,
  input  logic                 ready_in,
  output logic                 busy
`ifdef GON_SCHED_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  localparam int CNT_W = $clog2(NUM_PE + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("gon_multicast_scheduler: invalid FIFO_DEPTH or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {S_IDLE, S_CONFIG, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cfg_done_q, cfg_done_d;
  logic               set_id_q, set_id_d;
  logic [ID_LEN-1:0]  id_out_q, id_out_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [ID_LEN-1:0]    tag_mem_q [FIFO_DEPTH];
  logic [VALUE_LEN-1:0] val_mem_q [FIFO_DEPTH];

  logic empty, full, push, pop, timeout_hit;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = pkt_valid && !full;
  assign pop   = enable && (ready_in || timeout_hit);

`ifdef GON_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] stall_q, stall_d;
  logic          timeout_err_q, timeout_err_d;

  assign timeout_hit = enable && !ready_in && (stall_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    stall_d       = (!enable || pop) ? '0 : stall_q + TW'(1);
    timeout_err_d = timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      stall_q       <= stall_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cfg_done_q <= 1'b0;
      set_id_q   <= 1'b0;
      id_out_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_done_q <= cfg_done_d;
      set_id_q   <= set_id_d;
      id_out_q   <= id_out_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q[AW-1:0]] <= pkt_tag;
      val_mem_q[wr_ptr_q[AW-1:0]] <= pkt_value;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cfg_done_d = cfg_done_q;
    set_id_d   = 1'b0;
    id_out_d   = id_out_q;
    wr_ptr_d   = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d    = S_CONFIG;
          cnt_d      = '0;
          cfg_done_d = 1'b0;
        end
      end
      S_CONFIG: begin
        if (cfg_id_valid) begin
          set_id_d = 1'b1;
          id_out_d = cfg_id;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NUM_PE - 1)) begin
            state_d    = S_RUN;
            cfg_done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Reprogramming with packets in flight would deliver them to stale IDs.
        if (cfg_start && empty) begin
          state_d    = S_CONFIG;
          cnt_d      = '0;
          cfg_done_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_id_ready = (state_q == S_CONFIG);
    pkt_ready    = !full;
    enable       = (state_q == S_RUN) && !empty;
    tag          = enable ? tag_mem_q[rd_ptr_q[AW-1:0]] : '0;
    value        = enable ? val_mem_q[rd_ptr_q[AW-1:0]] : '0;
    busy         = (state_q != S_IDLE) || !empty;
  end

  assign cfg_done = cfg_done_q;
  assign set_id   = set_id_q;
  assign id_out   = id_out_q;

endmodule
